// File: rtl/stream_arbiter_2_1.sv
// Two-source packet arbiter: round-robin grant per packet, held until the last
// beat or an idle timeout, with a registered-owner 2:1 steer onto one channel.
module stream_arbiter_2_1 #(
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in0_valid,
  input  logic [DATA_W-1:0] in0_data,
  input  logic              in0_last,
  output logic              in0_ready,
  input  logic              in1_valid,
  input  logic [DATA_W-1:0] in1_data,
  input  logic              in1_last,
  output logic              in1_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic [1:0]        grant,
  output logic              timeout_evt
);

  // Encoding doubles as the one-hot grant vector.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0] IDLE_LIMIT = CNT_W'(TIMEOUT - 1);

  state_t             state, state_nxt;
  logic               rr_ptr, rr_ptr_nxt;
  logic [CNT_W-1:0]   idle_cnt, idle_cnt_nxt;
  logic               timeout_nxt;

  logic               owned;
  logic               sel_valid;
  logic               sel_last;
  logic [DATA_W-1:0]  sel_data;

  assign owned     = (state != IDLE);
  assign sel_valid = (state == OWN1) ? in1_valid : in0_valid;
  assign sel_last  = (state == OWN1) ? in1_last  : in0_last;
  assign sel_data  = (state == OWN1) ? in1_data  : in0_data;

  always_ff @(posedge clk) begin
    // NOTE: registers update with <= so every flop samples pre-edge values.
    if (rst) begin
      state       <= IDLE;
      rr_ptr      <= 1'b0;
      idle_cnt    <= '0;
      timeout_evt <= 1'b0;
    end else begin
      state       <= state_nxt;
      rr_ptr      <= rr_ptr_nxt;
      idle_cnt    <= idle_cnt_nxt;
      timeout_evt <= timeout_nxt;
    end
  end

  always_comb begin
    // NOTE: defaults first so no branch leaves a variable unassigned (no latch).
    state_nxt    = state;
    rr_ptr_nxt   = rr_ptr;
    idle_cnt_nxt = idle_cnt;
    timeout_nxt  = 1'b0;

    case (state)
      IDLE: begin
        idle_cnt_nxt = '0;
        if (in0_valid && in1_valid) begin
          state_nxt = rr_ptr ? OWN1 : OWN0;
        end else if (in0_valid) begin
          state_nxt = OWN0;
        end else if (in1_valid) begin
          state_nxt = OWN1;
        end
      end

      OWN0, OWN1: begin
        if (sel_valid) begin
          // Backpressure with valid high is not idleness.
          idle_cnt_nxt = '0;
          if (out_ready && sel_last) begin
            state_nxt  = IDLE;
            rr_ptr_nxt = (state == OWN0);
          end
        end else if (idle_cnt == IDLE_LIMIT) begin
          // TIMEOUT-th consecutive idle cycle: revoke; the pulse is seen
          // together with grant=00 on the following cycle.
          state_nxt    = IDLE;
          rr_ptr_nxt   = (state == OWN0);
          idle_cnt_nxt = '0;
          timeout_nxt  = 1'b1;
        end else begin
          idle_cnt_nxt = idle_cnt + CNT_W'(1);
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  // Gating with rst guarantees nothing transfers in the reset cycle itself.
  assign out_valid = owned & sel_valid & ~rst;
  assign out_data  = out_valid ? sel_data : '0;
  assign out_last  = out_valid & sel_last;
  assign in0_ready = (state == OWN0) & out_ready & ~rst;
  assign in1_ready = (state == OWN1) & out_ready & ~rst;
  assign grant     = state;

endmodule
